// File: rtl/chimera_cluster_pwr_ctrl_pkg.sv
// Shared types and defaults for the cluster power sequencer.
// Also holds the top-level configuration struct that gates its instantiation.
package chimera_cluster_pwr_ctrl_pkg;

    localparam int ExtClusters       = 5;
    localparam int DefaultRstCycles  = 4;
    localparam int DefaultIsoTimeout = 256;

    typedef struct packed {
        logic       IsolateClusters;
        logic [7:0] NumExtClusters;
    } chimera_cfg_t;

    typedef enum logic [2:0] {
        PwrOff,
        PwrWakeClk,
        PwrWakeDeiso,
        PwrOn,
        PwrSleepIso,
        PwrSleepRst
    } cluster_pwr_state_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_fsm.sv
// Per-cluster Moore power FSM: sequences clock gate, reset and AXI isolation.
// Timing comes from the shared counter in the parent; only the token holder advances.
module chimera_cluster_pwr_fsm
    import chimera_cluster_pwr_ctrl_pkg::*;
#(
    parameter int RstCycles  = DefaultRstCycles,
    parameter int IsoTimeout = DefaultIsoTimeout,
    parameter int CntW       = 9
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_req_i,
    input  logic            err_clr_i,
    input  logic            axi_isolated_i,
    input  logic            gnt_i,
    input  logic [CntW-1:0] cnt_i,
    output logic            req_o,
    output logic            done_o,
    output logic            step_o,
    output logic            clk_en_o,
    output logic            rst_o,
    output logic            isolate_o,
    output logic            on_o,
    output logic            err_o
);

    localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);

    cluster_pwr_state_e state, stateNext;
    logic errQ;
    logic errSet;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= PwrOff;
            errQ  <= 1'b0;
        end else begin
            state <= stateNext;
            // A timeout in the same cycle as a clear keeps the flag set
            if (errSet) begin
                errQ <= 1'b1;
            end else if (err_clr_i) begin
                errQ <= 1'b0;
            end
        end
    end

    assign req_o = !errQ && (((state == PwrOff) && en_req_i) ||
                             ((state == PwrOn) && !en_req_i));

    always_comb begin
        stateNext = state;
        errSet    = 1'b0;
        case (state)
            PwrOff:       if (gnt_i && req_o) stateNext = PwrWakeClk;
            PwrWakeClk:   if (cnt_i >= RstLast) stateNext = PwrWakeDeiso;
            PwrWakeDeiso: begin
                if (!axi_isolated_i) begin
                    stateNext = PwrOn;
                end else if (cnt_i >= IsoLast) begin
                    stateNext = PwrOn;
                    errSet    = 1'b1;
                end
            end
            PwrOn:        if (gnt_i && req_o) stateNext = PwrSleepIso;
            PwrSleepIso: begin
                if (axi_isolated_i) begin
                    stateNext = PwrSleepRst;
                end else if (cnt_i >= IsoLast) begin
                    stateNext = PwrOn;
                    errSet    = 1'b1;
                end
            end
            PwrSleepRst:  if (cnt_i >= RstLast) stateNext = PwrOff;
            default:      stateNext = PwrOff;
        endcase
    end

    assign step_o = (stateNext != state);
    assign done_o = (state != PwrOff) && (state != PwrOn) &&
                    ((stateNext == PwrOff) || (stateNext == PwrOn));

    always_comb begin
        clk_en_o  = 1'b0;
        rst_o     = 1'b1;
        isolate_o = 1'b1;
        on_o      = 1'b0;
        case (state)
            PwrWakeClk: begin
                clk_en_o = 1'b1;
            end
            PwrWakeDeiso: begin
                clk_en_o  = 1'b1;
                rst_o     = 1'b0;
                isolate_o = 1'b0;
            end
            PwrOn: begin
                clk_en_o  = 1'b1;
                rst_o     = 1'b0;
                isolate_o = 1'b0;
                on_o      = 1'b1;
            end
            PwrSleepIso: begin
                clk_en_o = 1'b1;
                rst_o    = 1'b0;
            end
            PwrSleepRst: begin
                clk_en_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_o = errQ;

endmodule

// File: rtl/chimera_cluster_pwr_ctrl.sv
// Cluster power controller: round-robin token so only one cluster changes power state at a time.
// The single timeout/reset counter is shared since at most one FSM is ever mid-transition.
module chimera_cluster_pwr_ctrl
    import chimera_cluster_pwr_ctrl_pkg::*;
#(
    parameter int NumClusters = ExtClusters,
    parameter int RstCycles   = DefaultRstCycles,
    parameter int IsoTimeout  = DefaultIsoTimeout
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] en_req_i,
    input  logic [NumClusters-1:0] err_clr_i,
    input  logic [NumClusters-1:0] axi_isolated_i,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_o,
    output logic [NumClusters-1:0] axi_isolate_o,
    output logic [NumClusters-1:0] cluster_on_o,
    output logic [NumClusters-1:0] err_o,
    output logic                   busy_o
);

    localparam int CntMax = maxInt(RstCycles, IsoTimeout);
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int IdxW   = (NumClusters > 1) ? $clog2(NumClusters) : 1;

    logic [NumClusters-1:0] req, gnt, done, step;
    logic                   tokenValid, tokenFree, pickValid;
    logic [IdxW-1:0]        tokenIdx, rrPtr, pickIdx;
    logic [CntW-1:0]        cnt;

    function automatic logic [CntW-1:0] satInc(input logic [CntW-1:0] v);
        return (v >= CntW'(CntMax)) ? v : v + 1'b1;
    endfunction

    function automatic logic [IdxW-1:0] nextIdx(input logic [IdxW-1:0] idx);
        return (int'(idx) >= NumClusters - 1) ? '0 : idx + 1'b1;
    endfunction

    // Search starts at the slot after the last grant
    always_comb begin
        int              cand;
        logic [IdxW-1:0] candIdx;
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        candIdx   = '0;
        for (int k = 0; k < NumClusters; k++) begin
            cand = int'(rrPtr) + k;
            if (cand >= NumClusters) cand = cand - NumClusters;
            candIdx = IdxW'(cand);
            if (!pickValid && req[candIdx]) begin
                pickValid = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    // Re-granting in the release cycle avoids a dead cycle between transitions
    assign tokenFree = !tokenValid || done[tokenIdx];

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NumClusters; i++) begin
            gnt[i] = tokenFree && pickValid && (pickIdx == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tokenValid <= 1'b0;
            tokenIdx   <= '0;
            rrPtr      <= '0;
            cnt        <= '0;
        end else begin
            if (tokenFree) begin
                tokenValid <= pickValid;
                if (pickValid) begin
                    tokenIdx <= pickIdx;
                    rrPtr    <= nextIdx(pickIdx);
                end
            end
            cnt <= (|step) ? '0 : satInc(cnt);
        end
    end

    assign busy_o = tokenValid;

    for (genvar g = 0; g < NumClusters; g++) begin : gen_fsm
        chimera_cluster_pwr_fsm #(
            .RstCycles  (RstCycles),
            .IsoTimeout (IsoTimeout),
            .CntW       (CntW)
        ) u_fsm (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .en_req_i       (en_req_i[g]),
            .err_clr_i      (err_clr_i[g]),
            .axi_isolated_i (axi_isolated_i[g]),
            .gnt_i          (gnt[g]),
            .cnt_i          (cnt),
            .req_o          (req[g]),
            .done_o         (done[g]),
            .step_o         (step[g]),
            .clk_en_o       (cluster_clk_en_o[g]),
            .rst_o          (cluster_rst_o[g]),
            .isolate_o      (axi_isolate_o[g]),
            .on_o           (cluster_on_o[g]),
            .err_o          (err_o[g])
        );
    end

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Scenario bench for chimera_cluster_pwr_ctrl with RstCycles=4, IsoTimeout=8.
// Expectations are queued per cycle up front and retired when that cycle is sampled.
module tb_chimera_cluster_pwr_ctrl;

    localparam int N = 5;

    localparam int SigClkEn  = 0;
    localparam int SigRst    = 1;
    localparam int SigIso    = 2;
    localparam int SigOn     = 3;
    localparam int SigErr    = 4;
    localparam int SigBusy   = 5;
    localparam int SigActive = 6;

    typedef struct {
        int           cyc;
        int           sig;
        logic [N-1:0] val;
        string        nm;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] enReq = '0;
    logic [N-1:0] errClr = '0;
    logic [N-1:0] stuckLow = '0;
    logic [N-1:0] isoDly;
    logic [N-1:0] axiIsolated;
    logic [N-1:0] clkEn, rstOut, axiIsolate, clusterOn, errOut;
    logic         busy;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Isolate-cell model: acknowledge follows the request one cycle later
    always @(posedge clk or posedge rst) begin
        if (rst) isoDly <= '1;
        else     isoDly <= axiIsolate;
    end
    assign axiIsolated = isoDly & ~stuckLow;

    chimera_cluster_pwr_ctrl #(
        .NumClusters (N),
        .RstCycles   (4),
        .IsoTimeout  (8)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_req_i         (enReq),
        .err_clr_i        (errClr),
        .axi_isolated_i   (axiIsolated),
        .cluster_clk_en_o (clkEn),
        .cluster_rst_o    (rstOut),
        .axi_isolate_o    (axiIsolate),
        .cluster_on_o     (clusterOn),
        .err_o            (errOut),
        .busy_o           (busy)
    );

    function automatic void pushExp(input int cyc, input int sig, input logic [N-1:0] val,
                                    input string nm);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = val;
        e.nm  = nm;
        sbQ.push_back(e);
    endfunction

    function automatic logic [N-1:0] observe(input int sig);
        case (sig)
            SigClkEn:  return clkEn;
            SigRst:    return rstOut;
            SigIso:    return axiIsolate;
            SigOn:     return clusterOn;
            SigErr:    return errOut;
            SigBusy:   return {{(N-1){1'b0}}, busy};
            SigActive: return N'($countones(clkEn & ~clusterOn));
            default:   return 'x;
        endcase
    endfunction

    task automatic doReset();
        rst      = 1'b1;
        enReq    = '0;
        errClr   = '0;
        stuckLow = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] obs;
        doReset();
        for (int c = 0; c < 20; c++) begin
            pushExp(c, SigClkEn, '0, "reset_clk_en");
            pushExp(c, SigRst,   '1, "reset_rst");
            pushExp(c, SigIso,   '1, "reset_iso");
            pushExp(c, SigBusy,  '0, "reset_busy");
        end
        pushExp(0, SigOn,  '0, "reset_on");
        pushExp(0, SigErr, '0, "reset_err");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == c) begin
                    obs = observe(sbQ[i].sig);
                    checks++;
                    if (obs !== sbQ[i].val) begin
                        errors++;
                        $display("FAIL %s @%0d: got %b, expected %b", sbQ[i].nm, c, obs, sbQ[i].val);
                    end
                    sbQ.delete(i);
                end
            end
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL reset_left: %0d expectations unretired, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_powerup();
        logic [N-1:0] obs;
        doReset();
        enReq = 5'b00100;
        pushExp(0, SigClkEn, 5'b00000, "pu_clk_en_c0");
        pushExp(0, SigBusy,  5'b00000, "pu_busy_c0");
        pushExp(1, SigClkEn, 5'b00100, "pu_clk_en_c1");
        pushExp(1, SigBusy,  5'b00001, "pu_busy_c1");
        pushExp(4, SigRst,   5'b11111, "pu_rst_c4");
        pushExp(4, SigIso,   5'b11111, "pu_iso_c4");
        pushExp(5, SigRst,   5'b11011, "pu_rst_c5");
        pushExp(5, SigIso,   5'b11011, "pu_iso_c5");
        pushExp(6, SigOn,    5'b00000, "pu_on_c6");
        pushExp(6, SigBusy,  5'b00001, "pu_busy_c6");
        pushExp(7, SigOn,    5'b00100, "pu_on_c7");
        pushExp(7, SigBusy,  5'b00000, "pu_busy_c7");
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == c) begin
                    obs = observe(sbQ[i].sig);
                    checks++;
                    if (obs !== sbQ[i].val) begin
                        errors++;
                        $display("FAIL %s @%0d: got %b, expected %b", sbQ[i].nm, c, obs, sbQ[i].val);
                    end
                    sbQ.delete(i);
                end
            end
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL pu_left: %0d expectations unretired, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] obs;
        doReset();
        enReq = '1;
        for (int c = 0; c <= 31; c++) begin
            pushExp(c, SigActive, (c == 0 || c == 31) ? 5'd0 : 5'd1, "b2b_active");
        end
        pushExp(1,  SigClkEn, 5'b00001, "b2b_clk_en_c1");
        pushExp(7,  SigClkEn, 5'b00011, "b2b_clk_en_c7");
        pushExp(6,  SigOn,    5'b00000, "b2b_on_c6");
        pushExp(7,  SigOn,    5'b00001, "b2b_on_c7");
        pushExp(13, SigOn,    5'b00011, "b2b_on_c13");
        pushExp(19, SigOn,    5'b00111, "b2b_on_c19");
        pushExp(25, SigOn,    5'b01111, "b2b_on_c25");
        pushExp(30, SigBusy,  5'b00001, "b2b_busy_c30");
        pushExp(31, SigOn,    5'b11111, "b2b_on_c31");
        pushExp(31, SigBusy,  5'b00000, "b2b_busy_c31");
        pushExp(32, SigBusy,  5'b00000, "b2b_busy_c32");
        pushExp(33, SigOn,    5'b10111, "b2b_on_c33");
        pushExp(33, SigIso,   5'b01000, "b2b_iso_c33");
        pushExp(33, SigBusy,  5'b00001, "b2b_busy_c33");
        pushExp(33, SigActive, 5'd1,    "b2b_active_c33");
        pushExp(34, SigRst,   5'b00000, "b2b_rst_c34");
        pushExp(35, SigRst,   5'b01000, "b2b_rst_c35");
        pushExp(38, SigClkEn, 5'b11111, "b2b_clk_en_c38");
        pushExp(39, SigClkEn, 5'b10111, "b2b_clk_en_c39");
        pushExp(39, SigBusy,  5'b00000, "b2b_busy_c39");
        pushExp(39, SigActive, 5'd0,    "b2b_active_c39");
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == c) begin
                    obs = observe(sbQ[i].sig);
                    checks++;
                    if (obs !== sbQ[i].val) begin
                        errors++;
                        $display("FAIL %s @%0d: got %b, expected %b", sbQ[i].nm, c, obs, sbQ[i].val);
                    end
                    sbQ.delete(i);
                end
            end
            if (c == 32) enReq = 5'b10111;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL b2b_left: %0d expectations unretired, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] obs;
        doReset();
        enReq = 5'b00010;
        pushExp(7,  SigOn,   5'b00010, "to_on_c7");
        pushExp(8,  SigIso,  5'b11111, "to_iso_c8");
        pushExp(15, SigIso,  5'b11111, "to_iso_c15");
        pushExp(15, SigErr,  5'b00000, "to_err_c15");
        pushExp(15, SigOn,   5'b00000, "to_on_c15");
        pushExp(15, SigBusy, 5'b00001, "to_busy_c15");
        pushExp(16, SigIso,  5'b11101, "to_iso_c16");
        pushExp(16, SigErr,  5'b00010, "to_err_c16");
        pushExp(16, SigOn,   5'b00010, "to_on_c16");
        pushExp(16, SigBusy, 5'b00000, "to_busy_c16");
        pushExp(21, SigOn,   5'b00010, "to_hold_on_c21");
        pushExp(21, SigBusy, 5'b00000, "to_hold_busy_c21");
        pushExp(22, SigErr,  5'b00010, "to_err_c22");
        pushExp(23, SigErr,  5'b00000, "to_err_clr_c23");
        pushExp(23, SigBusy, 5'b00000, "to_busy_c23");
        pushExp(24, SigBusy, 5'b00001, "to_busy_c24");
        pushExp(24, SigIso,  5'b11111, "to_iso_c24");
        pushExp(25, SigRst,  5'b11101, "to_rst_c25");
        pushExp(26, SigRst,  5'b11111, "to_rst_c26");
        pushExp(29, SigOn,   5'b00000, "to_on_c29");
        pushExp(29, SigClkEn, 5'b00010, "to_clk_en_c29");
        pushExp(30, SigClkEn, 5'b00000, "to_clk_en_c30");
        pushExp(30, SigBusy, 5'b00000, "to_busy_c30");
        for (int c = 0; c <= 31; c++) begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == c) begin
                    obs = observe(sbQ[i].sig);
                    checks++;
                    if (obs !== sbQ[i].val) begin
                        errors++;
                        $display("FAIL %s @%0d: got %b, expected %b", sbQ[i].nm, c, obs, sbQ[i].val);
                    end
                    sbQ.delete(i);
                end
            end
            if (c == 7) begin
                enReq    = 5'b00000;
                stuckLow = 5'b00010;
            end
            if (c == 22) begin
                stuckLow = 5'b00000;
                errClr   = 5'b00010;
            end
            if (c == 23) errClr = 5'b00000;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL to_left: %0d expectations unretired, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_toggle();
        logic [N-1:0] obs;
        doReset();
        enReq = 5'b00001;
        pushExp(2,  SigClkEn, 5'b00001, "tg_clk_en_c2");
        pushExp(6,  SigOn,    5'b00000, "tg_on_c6");
        pushExp(7,  SigOn,    5'b00001, "tg_on_c7");
        pushExp(7,  SigIso,   5'b11110, "tg_iso_c7");
        pushExp(7,  SigBusy,  5'b00000, "tg_busy_c7");
        pushExp(8,  SigOn,    5'b00000, "tg_on_c8");
        pushExp(8,  SigIso,   5'b11111, "tg_iso_c8");
        pushExp(8,  SigBusy,  5'b00001, "tg_busy_c8");
        pushExp(9,  SigRst,   5'b11110, "tg_rst_c9");
        pushExp(10, SigRst,   5'b11111, "tg_rst_c10");
        pushExp(13, SigClkEn, 5'b00001, "tg_clk_en_c13");
        pushExp(14, SigClkEn, 5'b00000, "tg_clk_en_c14");
        pushExp(14, SigBusy,  5'b00000, "tg_busy_c14");
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == c) begin
                    obs = observe(sbQ[i].sig);
                    checks++;
                    if (obs !== sbQ[i].val) begin
                        errors++;
                        $display("FAIL %s @%0d: got %b, expected %b", sbQ[i].nm, c, obs, sbQ[i].val);
                    end
                    sbQ.delete(i);
                end
            end
            if (c == 2) enReq = 5'b00000;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL tg_left: %0d expectations unretired, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] obs;
        doReset();
        enReq = 5'b00001;
        pushExp(10, SigRst,   5'b11111, "rm_rst_c10");
        pushExp(11, SigClkEn, 5'b00001, "rm_clk_en_c11");
        pushExp(11, SigIso,   5'b11111, "rm_iso_c11");
        pushExp(11, SigBusy,  5'b00001, "rm_busy_c11");
        pushExp(100, SigClkEn, 5'b00000, "rm_async_clk_en");
        pushExp(100, SigRst,   5'b11111, "rm_async_rst");
        pushExp(100, SigIso,   5'b11111, "rm_async_iso");
        pushExp(100, SigOn,    5'b00000, "rm_async_on");
        pushExp(100, SigBusy,  5'b00000, "rm_async_busy");
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == c) begin
                    obs = observe(sbQ[i].sig);
                    checks++;
                    if (obs !== sbQ[i].val) begin
                        errors++;
                        $display("FAIL %s @%0d: got %b, expected %b", sbQ[i].nm, c, obs, sbQ[i].val);
                    end
                    sbQ.delete(i);
                end
            end
            if (c == 2) enReq = 5'b00000;
        end
        // Assert reset mid-cycle and sample well before the next rising edge
        rst = 1'b1;
        #1;
        for (int i = sbQ.size() - 1; i >= 0; i--) begin
            if (sbQ[i].cyc == 100) begin
                obs = observe(sbQ[i].sig);
                checks++;
                if (obs !== sbQ[i].val) begin
                    errors++;
                    $display("FAIL %s: got %b, expected %b", sbQ[i].nm, obs, sbQ[i].val);
                end
                sbQ.delete(i);
            end
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL rm_left: %0d expectations unretired, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_powerup();
        test_back_to_back();
        test_timeout();
        test_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
